multicycle_controller: RTL and testbench

- Control FSM directly upstream of the multi-cycle CPU datapath.
- Consumes the datapath's registered opcode (inst[15:12]) and func (inst[8:0]).
- Drives every datapath control input plus the memory read/write strobes, sequencing FETCH/DECODE/EXECUTE/WRITEBACK per instruction.
- The datapath's PC, IR, MDR, A, B and ALU-out registers are the only state it relies on; the ALU-out register and MDR latch every cycle.

---
 rtl/cpu_ctrl_pkg.sv | 98 +++++++++
 rtl/func_alu_decoder.sv | 44 ++++
 rtl/multicycle_controller.sv | 172 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  localparam int DEF_OPC_W  = 4;
  localparam int DEF_FUNC_W = 9;

  // Controller states; IDLE is only ever seen while/just after reset.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEM_RD = 4'd3,
    S_WB_MEM = 4'd4,
    S_MEM_WR = 4'd5,
    S_JMP    = 4'd6,
    S_BRZ    = 4'd7,
    S_EX_R   = 4'd8,
    S_WB_R   = 4'd9,
    S_EX_I   = 4'd10,
    S_WB_I   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  // Opcodes (IR[15:12])
  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_HALT  = 4'b0011;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_RTYPE = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1100;
  localparam logic [3:0] OP_SUBI  = 4'b1101;
  localparam logic [3:0] OP_ANDI  = 4'b1110;
  localparam logic [3:0] OP_ORI   = 4'b1111;

  // R-type func bit positions (one-hot, lowest set bit wins)
  localparam int FN_MOVETO   = 0;
  localparam int FN_MOVEFROM = 1;
  localparam int FN_ADD      = 2;
  localparam int FN_SUB      = 3;
  localparam int FN_AND      = 4;
  localparam int FN_OR       = 5;
  localparam int FN_NOT      = 6;
  localparam int FN_NOP      = 7;
  localparam int FN_RSVD     = 8;

  // ALU operation codes; 3'b111 is reserved and never driven
  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_NOT    = 3'b100;
  localparam logic [2:0] ALU_PASS_A = 3'b101;
  localparam logic [2:0] ALU_PASS_B = 3'b110;

  // ALU B-operand and PC source selects
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_JMP  = 2'b01;
  localparam logic [1:0] PCSRC_BR   = 2'b10;

  // Full set of datapath controls, held in one register bank
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       ir_write;
    logic       reg_dst;
    logic       move_to;
    logic       data_from_mem;
    logic       no_op;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_opc;
    logic [1:0] pc_src;
    logic       mem_read;
    logic       mem_write;
    logic       halted;
  } ctrl_t;

  // Immediate-class ALU op comes straight from the low opcode bits
  function automatic logic [2:0] imm_aluop(input logic [1:0] sel);
    logic [2:0] op;
    case (sel)
      2'b00:   op = ALU_ADD;
      2'b01:   op = ALU_SUB;
      2'b10:   op = ALU_AND;
      default: op = ALU_OR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/func_alu_decoder.sv
// Decodes R-type func into ALU op plus MOVETO / NOP flags.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
module func_alu_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int FUNC_W = DEF_FUNC_W
) (
  input  logic [FUNC_W-1:0] i_func,
  output logic [2:0]        o_alu_opc,
  output logic              o_is_moveto,
  output logic              o_is_nop
);

  // Priority chain: the lowest set func bit selects the operation
  always_comb begin
    o_alu_opc   = ALU_ADD;
    o_is_moveto = 1'b0;
    o_is_nop    = 1'b0;
    if (i_func[FN_MOVETO]) begin
      o_alu_opc   = ALU_PASS_B;
      o_is_moveto = 1'b1;
    end else if (i_func[FN_MOVEFROM]) begin
      o_alu_opc = ALU_PASS_A;
    end else if (i_func[FN_ADD]) begin
      o_alu_opc = ALU_ADD;
    end else if (i_func[FN_SUB]) begin
      o_alu_opc = ALU_SUB;
    end else if (i_func[FN_AND]) begin
      o_alu_opc = ALU_AND;
    end else if (i_func[FN_OR]) begin
      o_alu_opc = ALU_OR;
    end else if (i_func[FN_NOT]) begin
      o_alu_opc = ALU_NOT;
    end else if (i_func[FN_NOP] || i_func[FN_RSVD]) begin
      // Architected NOP, and the reserved top bit behaves the same way
      o_is_nop = 1'b1;
    end else begin
      // An all-zero func has no operation to perform
      o_is_nop = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM sequencing FETCH/DECODE/EXECUTE/WRITEBACK for the multi-cycle datapath.
// Latency: outputs are registered and valid for the whole state they belong to; 2-4 cycles per instruction.
// Backpressure: none; advances every clock, HALT is left only through reset.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W  = DEF_OPC_W,
  parameter int FUNC_W = DEF_FUNC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FUNC_W-1:0] func,
  output logic              PcWrite,
  output logic              branch,
  output logic              IorD,
  output logic              IRWrite,
  output logic              regDst,
  output logic              moveTo,
  output logic              dataFromMem,
  output logic              noOp,
  output logic              regWrite,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [2:0]        ALUopc,
  output logic [1:0]        PcSrc,
  output logic              memRead,
  output logic              memWrite,
  output logic              halted
);

  state_t     r_state;
  ctrl_t      r_ctrl;
  state_t     w_next_state;
  ctrl_t      w_next_ctrl;
  logic [2:0] w_dec_opc;
  logic       w_dec_moveto;
  logic       w_dec_nop;

  func_alu_decoder #(
    .FUNC_W (FUNC_W)
  ) u_func_dec (
    .i_func      (func),
    .o_alu_opc   (w_dec_opc),
    .o_is_moveto (w_dec_moveto),
    .o_is_nop    (w_dec_nop)
  );

  // Successor state; opcode is only consulted in DECODE where IR is stable
  function automatic state_t next_state(input state_t s, input logic [OPC_W-1:0] opc);
    state_t n;
    case (s)
      S_IDLE:   n = S_FETCH;
      S_FETCH:  n = S_DECODE;
      S_DECODE: begin
        case (opc)
          OP_LOAD:  n = S_MEM_RD;
          OP_STORE: n = S_MEM_WR;
          OP_JUMP:  n = S_JMP;
          OP_HALT:  n = S_HALT;
          OP_BRZ:   n = S_BRZ;
          OP_RTYPE: n = S_EX_R;
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: n = S_EX_I;
          default:  n = S_FETCH;
        endcase
      end
      S_MEM_RD: n = S_WB_MEM;
      S_EX_R:   n = S_WB_R;
      S_EX_I:   n = S_WB_I;
      S_HALT:   n = S_HALT;
      default:  n = S_FETCH;
    endcase
    return n;
  endfunction

  // Control word for a state; EX_R/WB_R also depend on the decoded func
  function automatic ctrl_t ctrl_for(input state_t s, input logic [1:0] imm_sel,
                                     input logic [2:0] r_op, input logic is_mt,
                                     input logic is_nop);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_ONE;
        c.alu_opc   = ALU_ADD;
        c.pc_src    = PCSRC_ALU;
        c.pc_write  = 1'b1;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_WB_MEM: begin
        c.data_from_mem = 1'b1;
        c.reg_write     = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_JMP: begin
        c.pc_src   = PCSRC_JMP;
        c.pc_write = 1'b1;
      end
      S_BRZ: begin
        // PC loads only when the datapath reports zero on the SUB
        c.alu_src_b = SRCB_B;
        c.alu_opc   = ALU_SUB;
        c.branch    = 1'b1;
        c.pc_src    = PCSRC_BR;
      end
      S_EX_R: begin
        c.alu_src_b = SRCB_B;
        c.alu_opc   = r_op;
      end
      S_WB_R: begin
        c.reg_write = 1'b1;
        c.move_to   = is_mt;
        c.no_op     = is_nop;
      end
      S_EX_I: begin
        c.alu_src_b = SRCB_IMM;
        c.alu_opc   = imm_aluop(imm_sel);
      end
      S_WB_I: begin
        c.reg_write = 1'b1;
      end
      S_HALT: begin
        c.halted = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  assign w_next_state = next_state(r_state, opcode);
  assign w_next_ctrl  = ctrl_for(w_next_state, opcode[1:0], w_dec_opc,
                                 w_dec_moveto, w_dec_nop);

  // State and control word registered together so outputs line up with state;
  // reset clears both at once, which kills any in-flight writeback
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next_state;
      r_ctrl  <= w_next_ctrl;
    end
  end

  assign PcWrite     = r_ctrl.pc_write;
  assign branch      = r_ctrl.branch;
  assign IorD        = r_ctrl.iord;
  assign IRWrite     = r_ctrl.ir_write;
  assign regDst      = r_ctrl.reg_dst;
  assign moveTo      = r_ctrl.move_to;
  assign dataFromMem = r_ctrl.data_from_mem;
  assign noOp        = r_ctrl.no_op;
  assign regWrite    = r_ctrl.reg_write;
  assign ALUSrcA     = r_ctrl.alu_src_a;
  assign ALUSrcB     = r_ctrl.alu_src_b;
  assign ALUopc      = r_ctrl.alu_opc;
  assign PcSrc       = r_ctrl.pc_src;
  assign memRead     = r_ctrl.mem_read;
  assign memWrite    = r_ctrl.mem_write;
  assign halted      = r_ctrl.halted;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle control words from a scoreboard queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic [8:0] func;
  logic       PcWrite, branch, IorD, IRWrite, regDst, moveTo, dataFromMem, noOp;
  logic       regWrite, ALUSrcA, memRead, memWrite, halted;
  logic [1:0] ALUSrcB, PcSrc;
  logic [2:0] ALUopc;

  multicycle_controller dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .func        (func),
    .PcWrite     (PcWrite),
    .branch      (branch),
    .IorD        (IorD),
    .IRWrite     (IRWrite),
    .regDst      (regDst),
    .moveTo      (moveTo),
    .dataFromMem (dataFromMem),
    .noOp        (noOp),
    .regWrite    (regWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUopc      (ALUopc),
    .PcSrc       (PcSrc),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Bit positions of each control inside the packed observation word
  localparam int B_PCW = 19, B_BR = 18, B_IORD = 17, B_IRW = 16, B_RD = 15, B_MT = 14;
  localparam int B_DFM = 13, B_NOP = 12, B_RW = 11, B_SA = 10, B_SB = 8, B_OP = 5;
  localparam int B_PS = 3, B_MR = 2, B_MW = 1, B_H = 0;
  localparam logic [19:0] M_ALL   = 20'hFFFFF;
  localparam logic [19:0] M_NO_OP = 20'hFFF1F;  // ALUopc is a don't-care

  logic [19:0] act;
  assign act = {PcWrite, branch, IorD, IRWrite, regDst, moveTo, dataFromMem, noOp,
                regWrite, ALUSrcA, ALUSrcB, ALUopc, PcSrc, memRead, memWrite, halted};

  int checks = 0;
  int bad    = 0;
  logic [19:0] exp_q[$];
  logic [19:0] msk_q[$];

  function automatic logic [19:0] e_fetch();
    logic [19:0] v = '0;
    v[B_PCW] = 1'b1; v[B_IRW] = 1'b1; v[B_SA] = 1'b1; v[B_SB +: 2] = 2'b01; v[B_MR] = 1'b1;
    return v;
  endfunction
  function automatic logic [19:0] e_mem_rd();
    logic [19:0] v = '0; v[B_MR] = 1'b1; v[B_IORD] = 1'b1; return v;
  endfunction
  function automatic logic [19:0] e_wb_mem();
    logic [19:0] v = '0; v[B_DFM] = 1'b1; v[B_RW] = 1'b1; return v;
  endfunction
  function automatic logic [19:0] e_mem_wr();
    logic [19:0] v = '0; v[B_MW] = 1'b1; v[B_IORD] = 1'b1; return v;
  endfunction
  function automatic logic [19:0] e_jmp();
    logic [19:0] v = '0; v[B_PS +: 2] = 2'b01; v[B_PCW] = 1'b1; return v;
  endfunction
  function automatic logic [19:0] e_brz();
    logic [19:0] v = '0; v[B_OP +: 3] = 3'b001; v[B_BR] = 1'b1; v[B_PS +: 2] = 2'b10; return v;
  endfunction
  function automatic logic [19:0] e_ex(input logic [1:0] sb, input logic [2:0] op);
    logic [19:0] v = '0; v[B_SB +: 2] = sb; v[B_OP +: 3] = op; return v;
  endfunction
  function automatic logic [19:0] e_wb_r(input logic mt, input logic nop);
    logic [19:0] v = '0; v[B_RW] = 1'b1; v[B_MT] = mt; v[B_NOP] = nop; return v;
  endfunction
  function automatic logic [19:0] e_halt();
    logic [19:0] v = '0; v[B_H] = 1'b1; return v;
  endfunction

  // Reference R-type decode: scan for the lowest set bit, then map it
  function automatic logic [4:0] ref_rdec(input logic [8:0] fn);
    int idx = -1;
    for (int i = 8; i >= 0; i--) if (fn[i]) idx = i;
    case (idx)
      0:       return {3'b110, 1'b1, 1'b0};
      1:       return {3'b101, 1'b0, 1'b0};
      2:       return {3'b000, 1'b0, 1'b0};
      3:       return {3'b001, 1'b0, 1'b0};
      4:       return {3'b010, 1'b0, 1'b0};
      5:       return {3'b011, 1'b0, 1'b0};
      6:       return {3'b100, 1'b0, 1'b0};
      default: return {3'b000, 1'b0, 1'b1};
    endcase
  endfunction

  task automatic push(input logic [19:0] e, input logic [19:0] m);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  // Pop one expectation per clock and compare against the live outputs
  task automatic drain(input string name);
    logic [19:0] e, m;
    int step = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      checks++;
      if ((act & m) !== (e & m)) begin
        bad++;
        $display("FAIL %s step=%0d got=%05h want=%05h mask=%05h", name, step, act, e, m);
      end
      step++;
      @(posedge clk); #1;
    end
  endtask

  // Queue the full cycle-by-cycle control sequence of one instruction
  task automatic queue_instr(input logic [3:0] opc, input logic [8:0] fn);
    logic [4:0] rd;
    opcode = opc;
    func   = fn;
    push(e_fetch(), M_ALL);
    push('0, M_ALL);
    case (opc)
      4'b0000: begin push(e_mem_rd(), M_ALL); push(e_wb_mem(), M_ALL); end
      4'b0001: push(e_mem_wr(), M_ALL);
      4'b0010: push(e_jmp(), M_ALL);
      4'b0100: push(e_brz(), M_ALL);
      4'b1000: begin
        rd = ref_rdec(fn);
        push(e_ex(2'b00, rd[4:2]), rd[0] ? M_NO_OP : M_ALL);
        push(e_wb_r(rd[1], rd[0]), M_ALL);
      end
      4'b1100: begin push(e_ex(2'b10, 3'b000), M_ALL); push(e_wb_r(1'b0, 1'b0), M_ALL); end
      4'b1101: begin push(e_ex(2'b10, 3'b001), M_ALL); push(e_wb_r(1'b0, 1'b0), M_ALL); end
      4'b1110: begin push(e_ex(2'b10, 3'b010), M_ALL); push(e_wb_r(1'b0, 1'b0), M_ALL); end
      4'b1111: begin push(e_ex(2'b10, 3'b011), M_ALL); push(e_wb_r(1'b0, 1'b0), M_ALL); end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b0; opcode = 4'b0000; func = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act !== 20'h0) begin bad++; $display("FAIL reset_hold got=%05h want=00000", act); end
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if (act !== 20'h0) begin bad++; $display("FAIL reset_idle got=%05h want=00000", act); end
    @(posedge clk); #1;  // first edge after release enters FETCH
  endtask

  task automatic test_load();
    queue_instr(4'b0000, 9'h000);
    drain("load");
  endtask

  task automatic test_store_jump_brz();
    queue_instr(4'b0001, 9'h000); drain("store");
    queue_instr(4'b0010, 9'h1FF); drain("jump");
    queue_instr(4'b0100, 9'h000); drain("brz");
  endtask

  task automatic test_rtype();
    logic [8:0] fl [12] = '{9'b000000101, 9'b000000010, 9'b000000100, 9'b000001000,
                            9'b000010000, 9'b000100000, 9'b001000000, 9'b010000000,
                            9'b000000000, 9'b100000000, 9'b000011100, 9'b110000010};
    for (int k = 0; k < 12; k++) begin
      queue_instr(4'b1000, fl[k]);
      drain($sformatf("rtype_%03h", fl[k]));
    end
  endtask

  task automatic test_imm();
    for (int k = 12; k < 16; k++) begin
      queue_instr(4'(k), 9'h0A5);
      drain($sformatf("imm_%0d", k));
    end
  endtask

  task automatic test_undef();
    logic [3:0] ul [6] = '{4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010, 4'b1011};
    for (int k = 0; k < 6; k++) begin
      queue_instr(ul[k], 9'h001);
      drain($sformatf("undef_%0h", ul[k]));
    end
  endtask

  task automatic test_back_to_back();
    queue_instr(4'b0000, 9'h000); drain("b2b_load");
    queue_instr(4'b0001, 9'h000); drain("b2b_store");
    queue_instr(4'b1000, 9'b000000010); drain("b2b_movefrom");
    queue_instr(4'b0101, 9'h000); drain("b2b_undef");
    queue_instr(4'b1101, 9'h000); drain("b2b_subi");
  endtask

  task automatic test_reset_mid();
    opcode = 4'b1000; func = 9'b000001000;
    push(e_fetch(), M_ALL); push('0, M_ALL); push(e_ex(2'b00, 3'b001), M_ALL);
    drain("mid_pre");
    checks++;
    if (act !== e_wb_r(1'b0, 1'b0)) begin
      bad++; $display("FAIL mid_wb_r got=%05h want=%05h", act, e_wb_r(1'b0, 1'b0));
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (act !== 20'h0) begin bad++; $display("FAIL mid_async_clear got=%05h want=00000", act); end
    @(posedge clk); #1;
    checks++;
    if (act !== 20'h0) begin bad++; $display("FAIL mid_no_wb got=%05h want=00000", act); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    queue_instr(4'b0010, 9'h000); drain("after_mid_reset");
  endtask

  task automatic test_halt();
    opcode = 4'b0011; func = 9'h0FF;
    push(e_fetch(), M_ALL); push('0, M_ALL);
    for (int k = 0; k < 20; k++) push(e_halt(), M_ALL);
    drain("halt");
    checks++;
    if (act !== e_halt()) begin bad++; $display("FAIL halt_sticky got=%05h want=%05h", act, e_halt()); end
    rst = 1'b0; #1;
    checks++;
    if (act !== 20'h0) begin bad++; $display("FAIL halt_reset got=%05h want=00000", act); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    queue_instr(4'b0101, 9'h000); drain("after_halt");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load();
    test_store_jump_brz();
    test_rtype();
    test_imm();
    test_undef();
    test_back_to_back();
    test_reset_mid();
    test_halt();
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
